// File: rtl/sap_pkg.sv
// Shared widths and bus-source encoding for the SAP-style CPU datapath,
// its control unit and the bench.
package sap_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int RAM_DEPTH = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Which register currently owns the shared bus
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_PC,
        SRC_IR,
        SRC_A,
        SRC_ALU,
        SRC_RAM
    } bus_src_e;

endpackage

// File: rtl/sap_datapath_if.sv
// Control word, program-load port and status lines between the control
// unit (master) and the datapath (slave).
interface sap_datapath_if;
    import sap_pkg::*;

    logic  hlt;
    logic  mi_bar, ro_bar, io_bar, ii_bar, ai_bar, ao_bar;
    logic  eo_bar, bi_bar, co_bar, j_bar, fi_bar;
    logic  ri, su, oi, ce;
    logic  prog_we;
    addr_t prog_addr;
    data_t prog_data;

    logic [3:0] ir_hi;
    logic       cf, zf;
    data_t      out_val;
    logic       out_valid;
    addr_t      pc;
    data_t      bus;
    logic       bus_conflict;

    modport master (
        output hlt, mi_bar, ro_bar, io_bar, ii_bar, ai_bar, ao_bar,
               eo_bar, bi_bar, co_bar, j_bar, fi_bar, ri, su, oi, ce,
               prog_we, prog_addr, prog_data,
        input  ir_hi, cf, zf, out_val, out_valid, pc, bus, bus_conflict
    );

    modport slave (
        input  hlt, mi_bar, ro_bar, io_bar, ii_bar, ai_bar, ao_bar,
               eo_bar, bi_bar, co_bar, j_bar, fi_bar, ri, su, oi, ce,
               prog_we, prog_addr, prog_data,
        output ir_hi, cf, zf, out_val, out_valid, pc, bus, bus_conflict
    );

endinterface

// File: rtl/sap_ram16.sv
// 16x8 program/data RAM: synchronous write from either the program loader
// or the bus, asynchronous read at the MAR address.
module sap_ram16
    import sap_pkg::*;
(
    input  logic  clk,
    input  logic  prog_we,
    input  addr_t prog_addr,
    input  data_t prog_data,
    input  logic  ri_we,
    input  addr_t ri_addr,
    input  data_t ri_data,
    input  addr_t rd_addr,
    output data_t rd_data
);

    data_t mem_q [RAM_DEPTH];
    logic  wr_en;
    addr_t wr_addr;
    data_t wr_data;

    // Select the write port; the program loader wins over a bus write
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        wr_en   = prog_we | ri_we;
        wr_addr = ri_addr;
        wr_data = ri_data;
        if (prog_we) begin
            wr_addr = prog_addr;
            wr_data = prog_data;
        end
    end

    // Array write on the rising edge
    // NOTE: the array has no reset so it maps onto plain RAM and keeps its program across a CPU reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sap_datapath.sv
// SAP-style CPU datapath: bus mux, PC, MAR, IR, A/B, ALU, flags, output
// register and the RAM, driven by the active-low/active-high control word.
module sap_datapath
    import sap_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    sap_datapath_if.slave  dp
);

    logic co, ro, io, ao, eo, mi, ii, ai, bi, j, fi;
    assign co = ~dp.co_bar;
    assign ro = ~dp.ro_bar;
    assign io = ~dp.io_bar;
    assign ao = ~dp.ao_bar;
    assign eo = ~dp.eo_bar;
    assign mi = ~dp.mi_bar;
    assign ii = ~dp.ii_bar;
    assign ai = ~dp.ai_bar;
    assign bi = ~dp.bi_bar;
    assign j  = ~dp.j_bar;
    assign fi = ~dp.fi_bar;

    addr_t pc_q, pc_d, mar_q, mar_d;
    data_t ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic  cf_q, cf_d, zf_q, zf_d, out_valid_q, out_valid_d;

    data_t           ram_rd, bus, b_op, alu_sum;
    logic [DATA_W:0] alu_r;
    bus_src_e        bus_src;
    logic [2:0]      n_drv;

    sap_ram16 u_ram (
        .clk       (clk),
        .prog_we   (dp.prog_we),
        .prog_addr (dp.prog_addr),
        .prog_data (dp.prog_data),
        .ri_we     (dp.ri & ~dp.hlt),
        .ri_addr   (mar_q),
        .ri_data   (bus),
        .rd_addr   (mar_q),
        .rd_data   (ram_rd)
    );

    // 9-bit add; subtract is A + ~B + 1 so carry means "no borrow"
    always_comb begin
        b_op    = dp.su ? ~b_q : b_q;
        alu_r   = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, dp.su};
        alu_sum = alu_r[DATA_W-1:0];
    end

    // Bus arbitration: ro > eo > ao > io > co, flag any multi-driver cycle
    always_comb begin
        bus_src = SRC_NONE;
        if      (ro) bus_src = SRC_RAM;
        else if (eo) bus_src = SRC_ALU;
        else if (ao) bus_src = SRC_A;
        else if (io) bus_src = SRC_IR;
        else if (co) bus_src = SRC_PC;
        n_drv = 3'(ro) + 3'(eo) + 3'(ao) + 3'(io) + 3'(co);

        case (bus_src)
            SRC_RAM: bus = ram_rd;
            SRC_ALU: bus = alu_sum;
            SRC_A:   bus = a_q;
            SRC_IR:  bus = {4'h0, ir_q[3:0]};
            SRC_PC:  bus = {4'h0, pc_q};
            default: bus = '0;
        endcase
    end

    // Register next-state: loads from the bus, all frozen while halted
    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        cf_d        = cf_q;
        zf_d        = zf_q;
        out_valid_d = 1'b0;
        if (!dp.hlt) begin
            if (mi) mar_d = bus[ADDR_W-1:0];
            if (ii) ir_d  = bus;
            if (ai) a_d   = bus;
            if (bi) b_d   = bus;
            if (dp.oi) begin
                out_d       = bus;
                out_valid_d = 1'b1;
            end
            if (fi) begin
                cf_d = alu_r[DATA_W];
                zf_d = (alu_sum == '0);
            end
            if (j)          pc_d = bus[ADDR_W-1:0];
            else if (dp.ce) pc_d = pc_q + 1'b1;
        end
    end

    // Datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            cf_q        <= cf_d;
            zf_q        <= zf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dp.ir_hi        = ir_q[7:4];
    assign dp.cf           = cf_q;
    assign dp.zf           = zf_q;
    assign dp.out_val      = out_q;
    assign dp.out_valid    = out_valid_q;
    assign dp.pc           = pc_q;
    assign dp.bus          = bus;
    assign dp.bus_conflict = (n_drv > 3'd1);

endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: the stimulus process drives a control
// word each cycle, predicts the observable state from a behavioural model and
// queues it; a monitor samples the DUT mid-cycle and compares.
module tb_sap_datapath;
    import sap_pkg::*;

    localparam int MI = 1 << 0,  RO = 1 << 1,  IO = 1 << 2,  II = 1 << 3;
    localparam int AI = 1 << 4,  AO = 1 << 5,  EO = 1 << 6,  BI = 1 << 7;
    localparam int CO = 1 << 8,  J  = 1 << 9,  FI = 1 << 10, RI = 1 << 11;
    localparam int SU = 1 << 12, OI = 1 << 13, CE = 1 << 14, HLT = 1 << 15;
    localparam int PW = 1 << 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sap_datapath_if dp_if ();

    sap_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (dp_if)
    );

    typedef struct {
        int idx;
        int pc, ir_hi, cf, zf, outv, outvld, bus, conf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_step = 0;
    bit   stim_done = 0;

    // Behavioural model state
    int m_pc, m_mar, m_ir, m_a, m_b, m_cf, m_zf, m_out, m_outvld;
    int m_ram [16];

    function automatic bit has(input int m, input int f);
        return (m & f) != 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp_v);
        n_vec++;
        if (act !== 32'(exp_v)) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
        m_cf = 0; m_zf = 0; m_out = 0; m_outvld = 0;
    endtask

    // One CPU cycle: drive after the falling edge, predict, queue, advance model
    task automatic step(input int m, input int pa = 0, input int pd = 0, input bit rst_lvl = 1'b1);
        int   n, bus, sum, carry, raw;
        exp_t e;
        @(negedge clk);
        #1;
        dp_if.mi_bar    = !has(m, MI);
        dp_if.ro_bar    = !has(m, RO);
        dp_if.io_bar    = !has(m, IO);
        dp_if.ii_bar    = !has(m, II);
        dp_if.ai_bar    = !has(m, AI);
        dp_if.ao_bar    = !has(m, AO);
        dp_if.eo_bar    = !has(m, EO);
        dp_if.bi_bar    = !has(m, BI);
        dp_if.co_bar    = !has(m, CO);
        dp_if.j_bar     = !has(m, J);
        dp_if.fi_bar    = !has(m, FI);
        dp_if.ri        = has(m, RI);
        dp_if.su        = has(m, SU);
        dp_if.oi        = has(m, OI);
        dp_if.ce        = has(m, CE);
        dp_if.hlt       = has(m, HLT);
        dp_if.prog_we   = has(m, PW);
        dp_if.prog_addr = 4'(pa);
        dp_if.prog_data = 8'(pd);
        rst_n           = rst_lvl;
        if (!rst_lvl) model_reset();

        if (has(m, SU)) begin
            sum   = (m_a - m_b) & 255;
            carry = (m_a >= m_b) ? 1 : 0;
        end else begin
            raw   = m_a + m_b;
            sum   = raw & 255;
            carry = (raw > 255) ? 1 : 0;
        end

        n = int'(has(m, RO)) + int'(has(m, EO)) + int'(has(m, AO)) + int'(has(m, IO)) + int'(has(m, CO));
        if      (has(m, RO)) bus = m_ram[m_mar];
        else if (has(m, EO)) bus = sum;
        else if (has(m, AO)) bus = m_a;
        else if (has(m, IO)) bus = m_ir % 16;
        else if (has(m, CO)) bus = m_pc;
        else                 bus = 0;

        e.idx = n_step; e.pc = m_pc; e.ir_hi = m_ir / 16; e.cf = m_cf; e.zf = m_zf;
        e.outv = m_out; e.outvld = m_outvld; e.bus = bus; e.conf = (n > 1) ? 1 : 0;
        sb.push_back(e);
        n_step++;

        if (has(m, PW))                     m_ram[pa % 16] = pd & 255;
        else if (has(m, RI) && !has(m, HLT)) m_ram[m_mar] = bus;

        if (rst_lvl) begin
            m_outvld = 0;
            if (!has(m, HLT)) begin
                if (has(m, MI)) m_mar = bus % 16;
                if (has(m, II)) m_ir = bus;
                if (has(m, AI)) m_a = bus;
                if (has(m, BI)) m_b = bus;
                if (has(m, OI)) begin
                    m_out    = bus;
                    m_outvld = 1;
                end
                if (has(m, FI)) begin
                    m_cf = carry;
                    m_zf = (sum == 0) ? 1 : 0;
                end
                if (has(m, J))       m_pc = bus % 16;
                else if (has(m, CE)) m_pc = (m_pc + 1) % 16;
            end
        end
    endtask

    // Monitor: sample between the drive point and the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("pc@%0d", e.idx),           32'(dp_if.pc),           e.pc);
                check($sformatf("ir_hi@%0d", e.idx),        32'(dp_if.ir_hi),        e.ir_hi);
                check($sformatf("cf@%0d", e.idx),           32'(dp_if.cf),           e.cf);
                check($sformatf("zf@%0d", e.idx),           32'(dp_if.zf),           e.zf);
                check($sformatf("out_val@%0d", e.idx),      32'(dp_if.out_val),      e.outv);
                check($sformatf("out_valid@%0d", e.idx),    32'(dp_if.out_valid),    e.outvld);
                check($sformatf("bus@%0d", e.idx),          32'(dp_if.bus),          e.bus);
                check($sformatf("bus_conflict@%0d", e.idx), 32'(dp_if.bus_conflict), e.conf);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete, step %0d", n_step);
        $fatal(1, "timeout");
    end

    initial begin
        int m;
        dp_if.mi_bar = 1; dp_if.ro_bar = 1; dp_if.io_bar = 1; dp_if.ii_bar = 1;
        dp_if.ai_bar = 1; dp_if.ao_bar = 1; dp_if.eo_bar = 1; dp_if.bi_bar = 1;
        dp_if.co_bar = 1; dp_if.j_bar = 1;  dp_if.fi_bar = 1;
        dp_if.ri = 0; dp_if.su = 0; dp_if.oi = 0; dp_if.ce = 0; dp_if.hlt = 0;
        dp_if.prog_we = 0; dp_if.prog_addr = '0; dp_if.prog_data = '0;
        model_reset();

        step(0, 0, 0, 1'b0);
        step(0, 0, 0, 1'b0);

        // Program load under reset: LDA 14 / ADD 15, data at 3, 14, 15
        for (int i = 0; i < 16; i++) begin
            int v;
            case (i)
                0:       v = 8'h1E;
                1:       v = 8'h2F;
                3:       v = 8'h55;
                14:      v = 8'h1C;
                15:      v = 8'h0E;
                default: v = int'($urandom_range(0, 255));
            endcase
            step(PW, i, v, 1'b0);
        end
        step(0);

        // LDA 14 then ADD 15: A = 0x1C + 0x0E = 0x2A
        step(CO | MI); step(RO | II | CE); step(IO | MI); step(RO | AI);
        step(CO | MI); step(RO | II | CE); step(IO | MI); step(RO | BI);
        step(EO | AI | FI);

        // Subtract equal operands, then 1 - 2
        step(AO | BI); step(SU | EO | FI); step(0);
        step(PW, 15, 8'h01); step(RO | AI);
        step(PW, 15, 8'h02); step(RO | BI);
        step(SU | EO | FI); step(0);

        // Asynchronous reset with loads active, then release
        step(AI | CE | FI | MI | AO, 0, 0, 1'b0);
        step(0);

        // PC wrap through 16 increments, then read back RAM[3]
        for (int i = 0; i < 16; i++) step(CE);
        step(CE); step(CE); step(CE); step(CO | MI); step(RO | AI); step(AO);

        // Jump via IR operand beats simultaneous ce
        step(PW, 3, 8'h67); step(RO | II); step(IO | J | CE); step(0);

        // Halt blocks CPU loads but not program writes; write then read next cycle
        step(PW, 3, 8'h99);
        step(RO | AI | CE | FI | HLT | PW, 3, 8'hC3);
        step(RO | AO); step(AO);

        // Program write beats a bus write to the same word
        step(AO | RI | PW, 3, 8'h5A); step(RO);

        // Output register pulse and bus conflict
        step(PW, 3, 8'h2A); step(RO | AI);
        step(AO | OI); step(0); step(0);
        step(AO | CO);

        // Randomised control words
        for (int i = 0; i < 400; i++) begin
            m = 0;
            for (int b = 0; b < 15; b++)
                if ($urandom_range(0, 3) == 0) m |= (1 << b);
            if ($urandom_range(0, 7) == 0) m |= HLT;
            if ($urandom_range(0, 4) == 0) m |= PW;
            step(m, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
        end
        step(0); step(0);

        @(negedge clk);
        #5;
        stim_done = 1;
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
